// File: rtl/tour_replay_seq.sv
// Replays a solved knight's tour as two motion legs per move (long axis first, then short axis).
// Tracks the knight position and flags illegal starts, bad moves and off-board destinations.
module tour_replay_seq #(
   parameter int NUM_MOVES = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] x_start,
   input  logic [2:0] y_start,
   output logic       tour_go,
   input  logic       tour_done,
   output logic [4:0] indx,
   input  logic [7:0] move,
   output logic       cmd_vld,
   input  logic       cmd_rdy,
   output logic [1:0] cmd_hdg,
   output logic [1:0] cmd_sqrs,
   output logic       cmd_fanfare,
   input  logic       leg_cmplt,
   output logic [2:0] cur_x,
   output logic [2:0] cur_y,
   output logic       busy,
   output logic       tour_cmplt,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE, S_SOLVE, S_FETCH, S_DECODE, S_LEG1, S_WAIT1, S_LEG2, S_WAIT2
   } state_t;

   localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);

   state_t     r_state;
   logic [4:0] r_cnt;
   logic [2:0] r_cur_x, r_cur_y;
   logic       r_tour_go, r_tour_cmplt, r_err;
   logic       r_cmd_vld, r_cmd_fanfare;
   logic [1:0] r_cmd_hdg, r_cmd_sqrs, r_hdg2;

   logic signed [2:0] w_dx, w_dy;
   logic signed [3:0] w_nx, w_ny;
   logic              w_onehot, w_ok, w_xmaj;
   logic [1:0]        w_hdg_x, w_hdg_y, w_hdg1, w_hdg2;
   logic [2:0]        w_step_x, w_step_y;

   // Move table: each one-hot bit selects one of the eight knight offsets.
   always_comb begin
      w_dx     = 3'sd0;
      w_dy     = 3'sd0;
      w_onehot = 1'b1;
      case (move)
         8'h01:   begin w_dx = -3'sd1; w_dy =  3'sd2; end
         8'h02:   begin w_dx =  3'sd1; w_dy =  3'sd2; end
         8'h04:   begin w_dx = -3'sd2; w_dy =  3'sd1; end
         8'h08:   begin w_dx = -3'sd2; w_dy = -3'sd1; end
         8'h10:   begin w_dx = -3'sd1; w_dy = -3'sd2; end
         8'h20:   begin w_dx =  3'sd1; w_dy = -3'sd2; end
         8'h40:   begin w_dx =  3'sd2; w_dy = -3'sd1; end
         8'h80:   begin w_dx =  3'sd2; w_dy =  3'sd1; end
         default: w_onehot = 1'b0;
      endcase
   end

   assign w_nx    = $signed({1'b0, r_cur_x}) + {w_dx[2], w_dx};
   assign w_ny    = $signed({1'b0, r_cur_y}) + {w_dy[2], w_dy};
   assign w_ok    = w_onehot && !w_nx[3] && (w_nx <= 4'sd4) && !w_ny[3] && (w_ny <= 4'sd4);
   assign w_xmaj  = (w_dx == 3'sd2) || (w_dx == -3'sd2);
   assign w_hdg_x = w_dx[2] ? 2'b11 : 2'b01;
   assign w_hdg_y = w_dy[2] ? 2'b10 : 2'b00;
   assign w_hdg1  = w_xmaj ? w_hdg_x : w_hdg_y;
   assign w_hdg2  = w_xmaj ? w_hdg_y : w_hdg_x;

   // The accepted leg is still held in cmd_hdg/cmd_sqrs, so the position update uses it directly.
   always_comb begin
      w_step_x = r_cur_x;
      w_step_y = r_cur_y;
      case (r_cmd_hdg)
         2'b00: w_step_y = r_cur_y + {1'b0, r_cmd_sqrs};
         2'b01: w_step_x = r_cur_x + {1'b0, r_cmd_sqrs};
         2'b10: w_step_y = r_cur_y - {1'b0, r_cmd_sqrs};
         2'b11: w_step_x = r_cur_x - {1'b0, r_cmd_sqrs};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= 5'd0;
         r_cur_x       <= 3'd0;
         r_cur_y       <= 3'd0;
         r_tour_go     <= 1'b0;
         r_tour_cmplt  <= 1'b0;
         r_err         <= 1'b0;
         r_cmd_vld     <= 1'b0;
         r_cmd_fanfare <= 1'b0;
         r_cmd_hdg     <= 2'b00;
         r_cmd_sqrs    <= 2'b00;
         r_hdg2        <= 2'b00;
      end else begin
         r_tour_go    <= 1'b0;
         r_tour_cmplt <= 1'b0;
         if (abort && r_state != S_IDLE) begin
            r_state       <= S_IDLE;
            r_cmd_vld     <= 1'b0;
            r_cmd_fanfare <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     if (x_start <= 3'd4 && y_start <= 3'd4) begin
                        r_cur_x   <= x_start;
                        r_cur_y   <= y_start;
                        r_err     <= 1'b0;
                        r_tour_go <= 1'b1;
                        r_state   <= S_SOLVE;
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
               S_SOLVE: begin
                  if (tour_done) begin
                     r_cnt   <= 5'd0;
                     r_state <= S_FETCH;
                  end
               end
               S_FETCH:  r_state <= S_DECODE;
               S_DECODE: begin
                  if (w_ok) begin
                     r_cmd_hdg     <= w_hdg1;
                     r_cmd_sqrs    <= 2'd2;
                     r_hdg2        <= w_hdg2;
                     r_cmd_vld     <= 1'b1;
                     r_cmd_fanfare <= 1'b0;
                     r_state       <= S_LEG1;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
               S_LEG1: begin
                  if (cmd_rdy) begin
                     r_cmd_vld <= 1'b0;
                     r_state   <= S_WAIT1;
                  end
               end
               S_WAIT1: begin
                  if (leg_cmplt) begin
                     r_cur_x       <= w_step_x;
                     r_cur_y       <= w_step_y;
                     r_cmd_hdg     <= r_hdg2;
                     r_cmd_sqrs    <= 2'd1;
                     r_cmd_vld     <= 1'b1;
                     r_cmd_fanfare <= (r_cnt == LAST);
                     r_state       <= S_LEG2;
                  end
               end
               S_LEG2: begin
                  if (cmd_rdy) begin
                     r_cmd_vld     <= 1'b0;
                     r_cmd_fanfare <= 1'b0;
                     r_state       <= S_WAIT2;
                  end
               end
               S_WAIT2: begin
                  if (leg_cmplt) begin
                     r_cur_x <= w_step_x;
                     r_cur_y <= w_step_y;
                     if (r_cnt == LAST) begin
                        r_tour_cmplt <= 1'b1;
                        r_state      <= S_IDLE;
                     end else begin
                        r_cnt   <= r_cnt + 5'd1;
                        r_state <= S_FETCH;
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign tour_go     = r_tour_go;
   assign indx        = r_cnt;
   assign cmd_vld     = r_cmd_vld;
   assign cmd_hdg     = r_cmd_hdg;
   assign cmd_sqrs    = r_cmd_sqrs;
   assign cmd_fanfare = r_cmd_fanfare;
   assign cur_x       = r_cur_x;
   assign cur_y       = r_cur_y;
   assign busy        = (r_state != S_IDLE);
   assign tour_cmplt  = r_tour_cmplt;
   assign err         = r_err;

endmodule

// File: tb/tb_tour_replay_seq.sv
// Randomized tours through solver and motion stubs, checked against a move-list position model.
module tb_tour_replay_seq;
   localparam int NM = 24;

   logic       clk = 1'b0;
   logic       rst, start, abort, tour_done, cmd_rdy, leg_cmplt;
   logic [2:0] x_start, y_start;
   logic       tour_go, cmd_vld, cmd_fanfare, busy, tour_cmplt, err;
   logic [4:0] indx;
   logic [7:0] move;
   logic [1:0] cmd_hdg, cmd_sqrs;
   logic [2:0] cur_x, cur_y;

   logic [7:0] mv [0:31];
   int n_tot = 0;
   int n_bad = 0;
   int DX [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
   int DY [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

   tour_replay_seq #(.NUM_MOVES(NM)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .x_start(x_start), .y_start(y_start), .tour_go(tour_go), .tour_done(tour_done),
      .indx(indx), .move(move), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
      .cmd_hdg(cmd_hdg), .cmd_sqrs(cmd_sqrs), .cmd_fanfare(cmd_fanfare),
      .leg_cmplt(leg_cmplt), .cur_x(cur_x), .cur_y(cur_y), .busy(busy),
      .tour_cmplt(tour_cmplt), .err(err)
   );

   always #5 clk = ~clk;
   assign move = mv[indx];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int bit_of(input logic [7:0] m);
      for (int b = 0; b < 8; b++)
         if (m == (8'h01 << b)) return b;
      return -1;
   endfunction

   function automatic logic [1:0] hdg_of(input bit xaxis, input int d);
      if (xaxis) return (d < 0) ? 2'b11 : 2'b01;
      return (d < 0) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] pos(input int x, input int y);
      return 32'((x << 3) | y);
   endfunction

   task automatic gen_tour(input int sx, input int sy, input logic [7:0] first);
      int x, y, nc, b;
      int cand [8];
      x = sx;
      y = sy;
      for (int k = 0; k < 32; k++) mv[k] = 8'h00;
      for (int k = 0; k < NM; k++) begin
         if (k == 0 && first != 8'h00) begin
            b = bit_of(first);
         end else begin
            nc = 0;
            for (int i = 0; i < 8; i++)
               if (x + DX[i] >= 0 && x + DX[i] <= 4 && y + DY[i] >= 0 && y + DY[i] <= 4) begin
                  cand[nc] = i;
                  nc++;
               end
            b = (nc == 0) ? 7 : cand[$urandom_range(nc - 1)];
         end
         mv[k] = 8'h01 << b;
         x += DX[b];
         y += DY[b];
      end
   endtask

   // mode: 0 full tour, 1 bad move expected at move 'at', 2 abort in WAIT2 of 'at', 3 reset in WAIT1 of 'at'
   task automatic drive_tour(input int sx, input int sy, input int mode, input int at, input int solve_dly);
      int x, y, acc, b, dx, dy, w, stall;
      bit xmaj, last;
      logic [1:0] h, s;
      logic ff;
      x = sx;
      y = sy;
      acc = 0;
      check("idle_before", 32'(busy), 32'd0);
      start = 1'b1; x_start = 3'(sx); y_start = 3'(sy);
      tick;
      start = 1'b0;
      check("go_pulse", 32'(tour_go), 32'd1);
      check("busy_start", 32'(busy), 32'd1);
      check("err_clr", 32'(err), 32'd0);
      check("cur_load", 32'({cur_x, cur_y}), pos(x, y));
      tick;
      check("go_once", 32'(tour_go), 32'd0);
      start = 1'b1; x_start = 3'd5;
      repeat (solve_dly) tick;
      start = 1'b0;
      check("start_ignored", 32'({err, tour_go, busy}), 32'd1);
      tour_done = 1'b1;
      tick;
      tour_done = 1'b0;
      for (int k = 0; k < NM; k++) begin
         if (mode == 1 && k == at) begin
            for (int i = 0; i < 6; i++) begin
               check("bad_no_vld", 32'(cmd_vld), 32'd0);
               tick;
            end
            check("bad_err", 32'({err, busy}), 32'b10);
            return;
         end
         b = bit_of(mv[k]);
         dx = DX[b];
         dy = DY[b];
         xmaj = (dx == 2 || dx == -2);
         for (int leg = 0; leg < 2; leg++) begin
            h  = (leg == 0) ? hdg_of(xmaj, xmaj ? dx : dy) : hdg_of(!xmaj, xmaj ? dy : dx);
            s  = (leg == 0) ? 2'd2 : 2'd1;
            ff = (leg == 1 && k == NM - 1);
            w = 0;
            while (!cmd_vld && w < 20) begin
               tick;
               w++;
            end
            check("vld_seen", 32'(cmd_vld), 32'd1);
            if (!cmd_vld) return;
            check("indx", 32'(indx), 32'(k));
            stall = (k == 0 && leg == 0) ? 10 : $urandom_range(3);
            for (int i = 0; i < stall; i++) begin
               check("leg_hold", 32'({cmd_vld, cmd_hdg, cmd_sqrs, cmd_fanfare}), 32'({1'b1, h, s, ff}));
               leg_cmplt = (i == 2);
               tick;
               leg_cmplt = 1'b0;
            end
            check("leg_accept", 32'({cmd_vld, cmd_hdg, cmd_sqrs, cmd_fanfare}), 32'({1'b1, h, s, ff}));
            check("stall_cur", 32'({cur_x, cur_y}), pos(x, y));
            cmd_rdy = 1'b1;
            tick;
            cmd_rdy = 1'b0;
            acc++;
            check("vld_drop", 32'(cmd_vld), 32'd0);
            if (mode == 2 && k == at && leg == 1) begin
               abort = 1'b1; leg_cmplt = 1'b1;
               tick;
               abort = 1'b0; leg_cmplt = 1'b0;
               check("abort_idle", 32'({busy, cmd_vld, tour_cmplt, tour_go}), 32'd0);
               check("abort_hold", 32'({cur_x, cur_y}), pos(x, y));
               for (int i = 0; i < 3; i++) begin
                  tick;
                  check("abort_quiet", 32'({tour_cmplt, busy, cmd_vld}), 32'd0);
               end
               return;
            end
            if (mode == 3 && k == at && leg == 0) begin
               rst = 1'b1;
               tick;
               rst = 1'b0;
               check("rst_mid", 32'({tour_go, cmd_vld, cmd_fanfare, busy, tour_cmplt, err,
                                     indx, cmd_hdg, cmd_sqrs, cur_x, cur_y}), 32'd0);
               return;
            end
            repeat ($urandom_range(3)) tick;
            leg_cmplt = 1'b1;
            tick;
            leg_cmplt = 1'b0;
            if ((leg == 0) == xmaj) x += dx;
            else y += dy;
            check("cur", 32'({cur_x, cur_y}), pos(x, y));
            last = (k == NM - 1 && leg == 1);
            check("cmplt", 32'(tour_cmplt), 32'(last));
            if (last) check("busy_end", 32'(busy), 32'd0);
         end
      end
      check("n_accept", 32'(acc), 32'(2 * NM));
      tick;
      check("cmplt_once", 32'({tour_cmplt, busy}), 32'd0);
   endtask

   initial begin
      int sx, sy;
      rst = 1'b1; start = 1'b0; abort = 1'b0; tour_done = 1'b0;
      cmd_rdy = 1'b0; leg_cmplt = 1'b0; x_start = 3'd0; y_start = 3'd0;
      for (int k = 0; k < 32; k++) mv[k] = 8'h00;
      tick;
      tick;
      rst = 1'b0;
      check("reset_vals", 32'({tour_go, cmd_vld, cmd_fanfare, busy, tour_cmplt, err,
                               indx, cmd_hdg, cmd_sqrs, cur_x, cur_y}), 32'd0);

      gen_tour(0, 0, 8'h02);
      drive_tour(0, 0, 0, 0, 5);

      for (int t = 0; t < 2; t++) begin
         start = 1'b1;
         x_start = (t == 0) ? 3'd5 : 3'd1;
         y_start = (t == 0) ? 3'd0 : 3'd6;
         tick;
         start = 1'b0;
         check("bad_start", 32'({err, tour_go, busy}), 32'b100);
         repeat (3) tick;
         check("bad_start_idle", 32'({err, tour_go, busy}), 32'b100);
      end

      sx = $urandom_range(4); sy = $urandom_range(4);
      gen_tour(sx, sy, 8'h00);
      mv[3] = 8'h41;
      drive_tour(sx, sy, 1, 3, 2);

      gen_tour(0, 0, 8'h01);
      drive_tour(0, 0, 1, 0, 1);

      sx = $urandom_range(4); sy = $urandom_range(4);
      gen_tour(sx, sy, 8'h00);
      drive_tour(sx, sy, 2, 5, 3);

      sx = $urandom_range(4); sy = $urandom_range(4);
      gen_tour(sx, sy, 8'h00);
      drive_tour(sx, sy, 3, 10, 2);

      for (int r = 0; r < 2; r++) begin
         sx = $urandom_range(4); sy = $urandom_range(4);
         gen_tour(sx, sy, 8'h00);
         drive_tour(sx, sy, 0, 0, $urandom_range(6));
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule

// File: doc/tour_replay_seq.md
TOUR_REPLAY_SEQ -- requirements
Module: tour_replay_seq

Interface
REQ-001 SHALL have parameter NUM_MOVES, default 24, the number of moves replayed per tour.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to solve and replay a tour.
REQ-005 SHALL have port abort, input, 1 bit: cancel the tour in progress.
REQ-006 SHALL have port x_start, input, 3 bits: starting column, legal values 0..4.
REQ-007 SHALL have port y_start, input, 3 bits: starting row, legal values 0..4.
REQ-008 SHALL have port tour_go, output, 1 bit: one-cycle pulse to the tour solver.
REQ-009 SHALL have port tour_done, input, 1 bit: solver completion pulse.
REQ-010 SHALL have port indx, output, 5 bits: move index sent to the solver readout.
REQ-011 SHALL have port move, input, 8 bits: one-hot move returned for indx.
REQ-012 SHALL have port cmd_vld, output, 1 bit: leg command valid.
REQ-013 SHALL have port cmd_rdy, input, 1 bit: motion block accepts the command.
REQ-014 SHALL have port cmd_hdg, output, 2 bits: heading, 00=N(+y), 01=E(+x), 10=S(-y), 11=W(-x).
REQ-015 SHALL have port cmd_sqrs, output, 2 bits: squares to travel, value 1 or 2.
REQ-016 SHALL have port cmd_fanfare, output, 1 bit: marks the final leg of the tour.
REQ-017 SHALL have port leg_cmplt, input, 1 bit: motion block finished the accepted leg.
REQ-018 SHALL have outputs cur_x and cur_y, 3 bits each: tracked knight position.
REQ-019 SHALL have outputs busy (1 bit), tour_cmplt (1-cycle pulse) and err (1 bit, sticky).

Function
REQ-020 States SHALL be IDLE, SOLVE, FETCH, DECODE, LEG1, WAIT1, LEG2, WAIT2.
REQ-021 In IDLE with start=1 and x_start<=4 and y_start<=4, the block SHALL:
- load cur_x/cur_y from x_start/y_start;
- clear err;
- pulse tour_go for one cycle;
- enter SOLVE.
REQ-022 In IDLE with start=1 and x_start>4 or y_start>4, the block SHALL set err, stay in IDLE and not pulse tour_go.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 SOLVE SHALL wait for tour_done, then clear the move counter and enter FETCH.
REQ-025 indx SHALL equal the move counter at all times; FETCH SHALL last one cycle; DECODE SHALL register move.
REQ-026 Move decode SHALL be (dx,dy):
- bit0 = (-1,+2), bit1 = (+1,+2);
- bit2 = (-2,+1), bit3 = (-2,-1);
- bit4 = (-1,-2), bit5 = (+1,-2);
- bit6 = (+2,-1), bit7 = (+2,+1).
REQ-027 Leg 1 SHALL travel the axis with magnitude 2 (cmd_sqrs=2); leg 2 SHALL travel the axis with magnitude 1 (cmd_sqrs=1).
REQ-028 A registered move that is not one-hot, or whose destination lies outside 0..4, SHALL set err and return to IDLE without issuing a command.
REQ-029 In LEG1/LEG2, cmd_vld SHALL be 1 and cmd_hdg/cmd_sqrs SHALL be held stable until the cycle in which cmd_vld&&cmd_rdy; the state SHALL then advance to WAIT1/WAIT2.
REQ-030 leg_cmplt SHALL be honoured only in WAIT1/WAIT2; in other states it SHALL be ignored.
REQ-031 On leg_cmplt, cur_x/cur_y SHALL be updated by that leg's signed offset.
REQ-032 On leg_cmplt in WAIT1 the state SHALL go to LEG2.
REQ-033 On leg_cmplt in WAIT2, the counter SHALL increment and the state SHALL go to FETCH; if the counter was NUM_MOVES-1, the block SHALL instead pulse tour_cmplt and go to IDLE.
REQ-034 cmd_fanfare SHALL be 1 with cmd_vld only on LEG2 of move NUM_MOVES-1.
REQ-035 abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
- cmd_vld and tour_go SHALL be 0 from that edge;
- no tour_cmplt pulse;
- cur_x/cur_y SHALL hold;
- abort SHALL take priority over all simultaneous events.
REQ-036 busy SHALL be 1 whenever the state is not IDLE.
REQ-037 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from cmd_rdy to cmd_vld.

Reset
REQ-038 rst=1 at a rising edge SHALL force IDLE, including mid-tour.
REQ-039 Reset values SHALL be:
- tour_go, cmd_vld, cmd_fanfare, busy, tour_cmplt, err = 0;
- indx = 0; cmd_hdg = 00; cmd_sqrs = 00;
- cur_x = 0; cur_y = 0.
REQ-040 rst SHALL take priority over abort and start.

Verification
REQ-041 Start (0,0), stub tour_done after 5 cycles, move[0]=8'h02 -> tour_go one pulse; LEG1: hdg=00, sqrs=2; LEG2: hdg=01, sqrs=1; after both leg_cmplt, cur=(1,2).
REQ-042 cmd_rdy held low for 10 cycles in LEG1 -> cmd_vld=1 and fields stable for all 10 cycles; accept occurs on the first cycle cmd_rdy=1; leg_cmplt pulsed in LEG1 beforehand is ignored.
REQ-043 Full 24-move stub tour -> exactly 48 accepted commands; cmd_fanfare only on the 48th; tour_cmplt one pulse; busy=0 the cycle after.
REQ-044 start with x_start=5 -> err=1, tour_go never pulses, state stays IDLE; a following legal start clears err.
REQ-045 move=8'h41 at indx 3 -> err=1, IDLE, no cmd_vld; abort during WAIT2 -> IDLE next edge, no tour_cmplt.
REQ-046 rst asserted in WAIT1 of move 10 -> next cycle all outputs equal the REQ-039 values; a new start runs normally.
